// File: rtl/serial_gray_codec.sv
// serial_gray_codec
// Accepts a WIDTH-bit word over a valid/ready handshake, shifts it MSB-first
// through a 1-bit XOR-chain converter (Gray->binary or binary->Gray, chosen
// per word), and presents the reassembled word on an output valid/ready
// handshake. The converted serial stream is exposed for debug.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input word available
//   in_ready   block can accept a word (IDLE)
//   in_data    parallel input word
//   mode       0 = Gray->binary, 1 = binary->Gray; captured with the word
//   out_valid  converted word available (DONE)
//   out_ready  consumer accepts the word
//   out_data   converted parallel word; changes only while shifting
//   ser_bit    converted bit of the current cycle (meaningful while busy)
//   busy       conversion in progress (SHIFT)
module serial_gray_codec #(
   parameter int WIDTH = 5,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             ser_bit,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] sreg_r;
   logic [WIDTH-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             prev_r;
   logic             mode_r;
   logic             b_s;
   logic             ob_s;
   logic             last_s;

   // Serial converter core: current MSB XOR the previous chain bit.
   always_comb begin
      b_s    = sreg_r[WIDTH-1];
      ob_s   = prev_r ^ b_s;
      last_s = (cnt_r == CNT_W'(WIDTH - 1));
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; the unused encoding falls back to IDLE.
   always_comb begin
      state_s = IDLE;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Datapath: load the word in IDLE, shift one bit per cycle in SHIFT.
   // Gray->binary chains on the produced bit, binary->Gray on the input bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_r <= {WIDTH{1'b0}};
         acc_r  <= {WIDTH{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         prev_r <= 1'b0;
         mode_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sreg_r <= in_data;
                  mode_r <= mode;
                  prev_r <= 1'b0;
                  cnt_r  <= {CNT_W{1'b0}};
               end
            end
            SHIFT: begin
               sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
               acc_r  <= {acc_r[WIDTH-2:0], ob_s};
               cnt_r  <= cnt_r + CNT_W'(1);
               prev_r <= mode_r ? b_s : ob_s;
            end
            default: begin
               sreg_r <= sreg_r;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign busy      = (state_r == SHIFT);
   assign out_valid = (state_r == DONE);
   assign out_data  = acc_r;
   assign ser_bit   = busy ? ob_s : 1'b0;

endmodule

// File: tb/tb_serial_gray_codec.sv
// Self-checking bench for serial_gray_codec: a WIDTH=5 and a WIDTH=8 instance,
// directed steps plus random words, checked against arithmetic Gray models.
module tb_serial_gray_codec;

   logic       clk;
   logic       rst;

   logic       in_valid5, in_ready5, mode5, out_valid5, out_ready5, ser_bit5, busy5;
   logic [4:0] in_data5, out_data5;

   logic       in_valid8, in_ready8, mode8, out_valid8, out_ready8, ser_bit8, busy8;
   logic [7:0] in_data8, out_data8;

   int checks;
   int errors;

   serial_gray_codec #(.WIDTH(5)) dut5 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5), .mode(mode5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
      .ser_bit(ser_bit5), .busy(busy5)
   );

   serial_gray_codec #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .mode(mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .ser_bit(ser_bit8), .busy(busy8)
   );

   always #5 clk = ~clk;

   // Reference: each binary bit is the parity of all Gray bits at or above it.
   function automatic logic [31:0] g2b(input logic [31:0] g);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 32; i++) begin
         r[i] = ^(g >> i);
      end
      return r;
   endfunction

   function automatic logic [31:0] b2g(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Send one word to the 5-bit instance and check latency, serial stream and result.
   task automatic run5(input logic [4:0] d, input logic m, input bit disturb, input string tag);
      logic [4:0] exp;
      logic [4:0] ser;
      int lat;
      exp = m ? 5'(b2g({27'd0, d})) : 5'(g2b({27'd0, d}));
      check({tag, "_in_ready"}, {31'd0, in_ready5}, 32'd1);
      in_valid5 = 1'b1;
      in_data5  = d;
      mode5     = m;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      in_data5  = 5'($urandom);
      lat = 0;
      ser = 5'd0;
      while (out_valid5 !== 1'b1 && lat < 40) begin
         if (busy5 === 1'b1) ser = {ser[3:0], ser_bit5};
         if (disturb && lat == 2) begin
            mode5    = ~m;
            in_data5 = ~d;
         end
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 32'd5);
      check({tag, "_out_data"}, {27'd0, out_data5}, {27'd0, exp});
      check({tag, "_ser_bits"}, {27'd0, ser}, {27'd0, exp});
      if (out_ready5 === 1'b1) begin
         @(posedge clk); #1;
         check({tag, "_back_idle"}, {30'd0, in_ready5, out_valid5}, 32'd2);
         check({tag, "_out_hold"}, {27'd0, out_data5}, {27'd0, exp});
      end
   endtask

   // Send one word to the 8-bit instance; returns the observed result.
   task automatic run8(input logic [7:0] d, input logic m, output logic [7:0] res);
      logic [7:0] exp;
      logic [7:0] ser;
      int lat;
      exp = m ? 8'(b2g({24'd0, d})) : 8'(g2b({24'd0, d}));
      in_valid8 = 1'b1;
      in_data8  = d;
      mode8     = m;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 0;
      ser = 8'd0;
      while (out_valid8 !== 1'b1 && lat < 40) begin
         if (busy8 === 1'b1) ser = {ser[6:0], ser_bit8};
         @(posedge clk); #1;
         lat++;
      end
      res = out_data8;
      check("w8_latency", lat, 32'd8);
      check("w8_out_data", {24'd0, out_data8}, {24'd0, exp});
      check("w8_ser_bits", {24'd0, ser}, {24'd0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] g;
      logic [7:0] back;
      logic [7:0] prev_g;
      logic [4:0] rd;
      logic       rm;
      checks = 0;
      errors = 0;
      clk = 1'b0;
      rst = 1'b1;
      in_valid5 = 1'b0; in_data5 = 5'd0; mode5 = 1'b0; out_ready5 = 1'b1;
      in_valid8 = 1'b0; in_data8 = 8'd0; mode8 = 1'b0; out_ready8 = 1'b1;
      prev_g = 8'd0;

      // Reset state
      #12;
      check("rst_in_ready", {31'd0, in_ready5}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid5}, 32'd0);
      check("rst_out_data", {27'd0, out_data5}, 32'd0);
      check("rst_ser_bit", {31'd0, ser_bit5}, 32'd0);
      check("rst_busy", {31'd0, busy5}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed conversions
      run5(5'b10110, 1'b0, 1'b0, "g2b_10110");
      run5(5'b11011, 1'b1, 1'b0, "b2g_11011");
      run5(5'b11111, 1'b0, 1'b0, "g2b_11111");
      run5(5'b00000, 1'b0, 1'b0, "g2b_zero");
      run5(5'b00000, 1'b1, 1'b0, "b2g_zero");

      // Backpressure: result held, no new word accepted
      out_ready5 = 1'b0;
      run5(5'b10110, 1'b0, 1'b0, "bp");
      for (int i = 0; i < 10; i++) begin
         in_valid5 = 1'b1;
         in_data5  = 5'($urandom);
         mode5     = 1'b1;
         @(posedge clk); #1;
         check("bp_out_valid", {31'd0, out_valid5}, 32'd1);
         check("bp_out_data", {27'd0, out_data5}, 32'h1b);
         check("bp_in_ready", {31'd0, in_ready5}, 32'd0);
      end
      in_valid5  = 1'b0;
      out_ready5 = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {30'd0, in_ready5, out_valid5}, 32'd2);
      @(posedge clk); #1;
      check("bp_not_accepted", {31'd0, busy5}, 32'd0);

      // Mode and data change mid-word
      run5(5'b10110, 1'b0, 1'b1, "midword");

      // Asynchronous reset in the middle of SHIFT
      in_valid5 = 1'b1;
      in_data5  = 5'b10110;
      mode5     = 1'b0;
      @(posedge clk); #1;
      in_valid5 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy5}, 32'd0);
      check("arst_out_valid", {31'd0, out_valid5}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready5}, 32'd1);
      check("arst_out_data", {27'd0, out_data5}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_no_partial", {31'd0, out_valid5}, 32'd0);
      run5(5'b01000, 1'b0, 1'b0, "after_rst");

      // Random words with random modes and random idle gaps
      for (int i = 0; i < 24; i++) begin
         rd = 5'($urandom);
         rm = 1'($urandom);
         run5(rd, rm, 1'($urandom), "rand");
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      // 8-bit instance: MSB-only Gray word, then full round-trip sweep
      run8(8'h80, 1'b0, back);
      check("w8_80", {24'd0, back}, 32'hff);
      for (int v = 0; v < 256; v++) begin
         run8(8'(v), 1'b1, g);
         run8(g, 1'b0, back);
         check("w8_roundtrip", {24'd0, back}, v);
         if (v > 0) begin
            check("w8_one_bit_step", $countones(g ^ prev_g), 32'd1);
         end
         prev_g = g;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
